// File: rtl/apb_master_bridge.sv
// Valid/ready command stream to single APB transfers: sequences the SETUP and
// ACCESS phases, absorbs slave wait states and returns one response per command.
//
//  state  | meaning
//  -------+--------------------------------------------------------------
//  IDLE   | no transfer in flight, cmd_ready high, response pulse lives here
//  SETUP  | PSELx high, PENABLE low, address/data/direction presented
//  ACCESS | PSELx and PENABLE high, waiting for PREADY or the timeout
module apb_master_bridge #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int TIMEOUT    = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,

    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_timeout,

    output logic                  PSELx,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic                  PREADY,
    input  logic [DATA_WIDTH-1:0] PRDATA
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    // Abort fires on the edge where the counter has already seen TIMEOUT-1 waits,
    // so the counter never needs to reach TIMEOUT and never wraps.
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT < 1) ? '0 : CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    state_t                state, state_nx;
    logic [CW-1:0]         wait_cnt, wait_cnt_nx;
    logic                  psel_nx, penable_nx, pwrite_nx;
    logic [ADDR_WIDTH-1:0] paddr_nx;
    logic [DATA_WIDTH-1:0] pwdata_nx;
    logic                  rsp_valid_nx, rsp_timeout_nx;
    logic [DATA_WIDTH-1:0] rsp_rdata_nx;

    assign cmd_ready = (state == IDLE) & ~PRESET;

    always_comb begin
        state_nx       = state;
        wait_cnt_nx    = wait_cnt;
        psel_nx        = PSELx;
        penable_nx     = PENABLE;
        pwrite_nx      = PWRITE;
        paddr_nx       = PADDR;
        pwdata_nx      = PWDATA;
        rsp_valid_nx   = 1'b0;
        rsp_timeout_nx = 1'b0;
        rsp_rdata_nx   = rsp_rdata;

        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    pwrite_nx   = cmd_write;
                    paddr_nx    = cmd_addr;
                    pwdata_nx   = cmd_wdata;
                    psel_nx     = 1'b1;
                    penable_nx  = 1'b0;
                    wait_cnt_nx = '0;
                    state_nx    = SETUP;
                end
            end

            SETUP: begin
                penable_nx = 1'b1;
                state_nx   = ACCESS;
            end

            ACCESS: begin
                if (PREADY) begin
                    psel_nx        = 1'b0;
                    penable_nx     = 1'b0;
                    rsp_valid_nx   = 1'b1;
                    rsp_timeout_nx = 1'b0;
                    rsp_rdata_nx   = PWRITE ? '0 : PRDATA;
                    wait_cnt_nx    = '0;
                    state_nx       = IDLE;
                end else if (TIMEOUT != 0) begin
                    if (wait_cnt == CNT_LAST) begin
                        psel_nx        = 1'b0;
                        penable_nx     = 1'b0;
                        rsp_valid_nx   = 1'b1;
                        rsp_timeout_nx = 1'b1;
                        rsp_rdata_nx   = '0;
                        wait_cnt_nx    = '0;
                        state_nx       = IDLE;
                    end else begin
                        wait_cnt_nx = wait_cnt + 1'b1;
                    end
                end
            end

            default: begin
                psel_nx     = 1'b0;
                penable_nx  = 1'b0;
                wait_cnt_nx = '0;
                state_nx    = IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            PSELx       <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            rsp_valid   <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= '0;
        end else begin
            state       <= state_nx;
            wait_cnt    <= wait_cnt_nx;
            PSELx       <= psel_nx;
            PENABLE     <= penable_nx;
            PWRITE      <= pwrite_nx;
            PADDR       <= paddr_nx;
            PWDATA      <= pwdata_nx;
            rsp_valid   <= rsp_valid_nx;
            rsp_timeout <= rsp_timeout_nx;
            rsp_rdata   <= rsp_rdata_nx;
        end
    end

endmodule
